// File: rtl/arch_cdc_handshake_rx_if.sv
// Bundle for the toggle req/ack CDC receiver: source-side request/data,
// acknowledge back, and the AXI-Stream-style output stream.
interface arch_cdc_handshake_rx_if #(
    parameter int WIDTH = 8
);
    logic             src_req;
    logic [WIDTH-1:0] src_data;
    logic             dst_ack;
    logic             m_tvalid;
    logic             m_tready;
    logic [WIDTH-1:0] m_tdata;
    logic             busy;

    modport master (
        input  src_req,
        input  src_data,
        output dst_ack,
        output m_tvalid,
        input  m_tready,
        output m_tdata,
        output busy
    );

    modport slave (
        output src_req,
        output src_data,
        input  dst_ack,
        input  m_tvalid,
        output m_tready,
        input  m_tdata,
        input  busy
    );
endinterface

// File: rtl/arch_cdc_handshake_rx.sv
// Destination side of a two-phase req/ack CDC for multi-bit words.
// Optional ARCH_CDC_HS_COUNT_EN adds a 16-bit accepted-beat counter.
module arch_cdc_handshake_rx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 3
) (
    input  logic                          dst_clk,
    input  logic                          dst_rst,
`ifdef ARCH_CDC_HS_COUNT_EN
    output logic [15:0]                   xfer_count,
`endif
    arch_cdc_handshake_rx_if.master       bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAMPLE,
        S_VALID
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   w_req_s;
    logic                   r_ack;
    logic                   r_tvalid;
    logic [WIDTH-1:0]       r_tdata;
    logic                   w_pending;
    logic                   w_load;
    logic                   w_accept;

    assign w_req_s   = r_req_sync[SYNC_STAGES-1];
    assign w_pending = w_req_s ^ r_ack;

    assign bus.dst_ack  = r_ack;
    assign bus.m_tvalid = r_tvalid;
    assign bus.m_tdata  = r_tdata;
    assign bus.busy     = (r_state != S_IDLE);

    // Plain shift-register synchroniser on the request toggle.
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            r_req_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], bus.src_req};
        end
    end

    // State register.
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-state load/accept strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_pending) begin
                    w_state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                w_load      = 1'b1;
                w_state_nxt = S_VALID;
            end
            S_VALID: begin
                if (r_tvalid && bus.m_tready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Capture the word once, hold it until accepted, then toggle ack.
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_ack    <= 1'b0;
        end else if (w_load) begin
            r_tdata  <= bus.src_data;
            r_tvalid <= 1'b1;
        end else if (w_accept) begin
            r_tvalid <= 1'b0;
            r_ack    <= ~r_ack;
        end
    end

`ifdef ARCH_CDC_HS_COUNT_EN
    logic [15:0] r_xfer_count;

    assign xfer_count = r_xfer_count;

    // Count accepted beats; wraps naturally at 16 bits.
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            r_xfer_count <= '0;
        end else if (w_accept) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_arch_cdc_handshake_rx.sv
// Bench for arch_cdc_handshake_rx: directed vector table, reset corner
// cases, and a randomized source/sink run against a scoreboard queue.
module tb_arch_cdc_handshake_rx;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    arch_cdc_handshake_rx_if #(.WIDTH(8)) bus ();

`ifdef ARCH_CDC_HS_COUNT_EN
    logic [15:0] xfer_count;
`endif

    arch_cdc_handshake_rx #(
        .WIDTH      (8),
        .SYNC_STAGES(3)
    ) dut (
        .dst_clk   (clk),
        .dst_rst   (rst),
`ifdef ARCH_CDC_HS_COUNT_EN
        .xfer_count(xfer_count),
`endif
        .bus       (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        int         stall;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t       vecs[6];
    logic       exp_ack;
    logic [7:0] q[$];
    int         n_acc;

    initial begin
        vecs[0] = '{8'hA5, 0,  8'hA5, 5};
        vecs[1] = '{8'hA5, 10, 8'hA5, 5};
        vecs[2] = '{8'h01, 0,  8'h01, 5};
        vecs[3] = '{8'h02, 2,  8'h02, 5};
        vecs[4] = '{8'h03, 0,  8'h03, 5};
        vecs[5] = '{8'h04, 1,  8'h04, 5};

        rst          = 1'b1;
        bus.src_req  = 1'b0;
        bus.src_data = 8'h00;
        bus.m_tready = 1'b0;
        exp_ack      = 1'b0;
        n_acc        = 0;
        repeat (3) cyc();
        chk("rst_tvalid", 32'(bus.m_tvalid), 0);
        chk("rst_tdata",  32'(bus.m_tdata),  0);
        chk("rst_ack",    32'(bus.dst_ack),  0);
        chk("rst_busy",   32'(bus.busy),     0);

        // Reset held: activity on the inputs must not leak out.
        bus.src_req  = 1'b1;
        bus.m_tready = 1'b1;
        bus.src_data = 8'h77;
        repeat (8) cyc();
        chk("rsthold_tvalid", 32'(bus.m_tvalid), 0);
        chk("rsthold_ack",    32'(bus.dst_ack),  0);
        chk("rsthold_busy",   32'(bus.busy),     0);
        bus.src_req  = 1'b0;
        bus.m_tready = 1'b0;
        cyc();
        rst = 1'b0;
        repeat (4) cyc();

        // Directed vectors: latency, hold under backpressure, ack toggle.
        for (int v = 0; v < 6; v++) begin
            int n;
            bus.src_data = vecs[v].data;
            bus.m_tready = (vecs[v].stall == 0);
            bus.src_req  = ~bus.src_req;
            n = 0;
            while (!bus.m_tvalid && n < 20) begin
                cyc();
                n++;
            end
            chk($sformatf("v%0d_lat", v), n, vecs[v].exp_lat);
            chk($sformatf("v%0d_data", v), 32'(bus.m_tdata),
                32'(vecs[v].exp_data));
            for (int k = 0; k < vecs[v].stall; k++) begin
                bus.src_data = 8'h3C;
                cyc();
                chk($sformatf("v%0d_hold_v", v), 32'(bus.m_tvalid), 1);
                chk($sformatf("v%0d_hold_d", v), 32'(bus.m_tdata),
                    32'(vecs[v].exp_data));
                chk($sformatf("v%0d_hold_ack", v), 32'(bus.dst_ack),
                    32'(exp_ack));
            end
            bus.m_tready = 1'b1;
            cyc();
            exp_ack = ~exp_ack;
            chk($sformatf("v%0d_ack", v), 32'(bus.dst_ack), 32'(exp_ack));
            chk($sformatf("v%0d_tv0", v), 32'(bus.m_tvalid), 0);
            chk($sformatf("v%0d_busy", v), 32'(bus.busy), 0);
            bus.m_tready = 1'b0;
            repeat (2) cyc();
            chk($sformatf("v%0d_nobeat", v), 32'(bus.m_tvalid), 0);
        end
        chk("seq_ack_final", 32'(bus.dst_ack), 0);

        // Reset in VALID with src_req high, then replay of current word.
        begin
            int n;
            bus.src_data = 8'h5A;
            bus.src_req  = 1'b1;
            bus.m_tready = 1'b0;
            n = 0;
            while (!bus.m_tvalid && n < 20) begin
                cyc();
                n++;
            end
            chk("mid_valid", 32'(bus.m_tvalid), 1);
            rst = 1'b1;
            cyc();
            chk("mid_rst_tvalid", 32'(bus.m_tvalid), 0);
            chk("mid_rst_ack",    32'(bus.dst_ack),  0);
            chk("mid_rst_tdata",  32'(bus.m_tdata),  0);
            rst          = 1'b0;
            exp_ack      = 1'b0;
            bus.src_data = 8'hC3;
            n = 0;
            while (!bus.m_tvalid && n < 20) begin
                cyc();
                n++;
            end
            chk("replay_lat",  n, 5);
            chk("replay_data", 32'(bus.m_tdata), 32'h0000_00C3);
            bus.m_tready = 1'b1;
            cyc();
            exp_ack = 1'b1;
            chk("replay_ack", 32'(bus.dst_ack), 32'(exp_ack));
            bus.m_tready = 1'b0;
            repeat (8) cyc();
            chk("replay_once", 32'(bus.m_tvalid), 0);
        end

        // Randomized source/sink against a FIFO scoreboard.
        begin
            logic       src_busy;
            logic       pre_acc;
            logic       pre_hold;
            logic [7:0] pre_data;
            int         wait_cnt;
            src_busy = 1'b0;
            wait_cnt = 0;
            n_acc    = 0;
            for (int c = 0; c < 3000; c++) begin
                if (src_busy && bus.dst_ack == bus.src_req) begin
                    src_busy = 1'b0;
                    wait_cnt = 0;
                end
                if (!src_busy && c < 2900 && $urandom_range(0, 3) == 0) begin
                    bus.src_data = 8'($urandom);
                    q.push_back(bus.src_data);
                    bus.src_req  = ~bus.src_req;
                    src_busy     = 1'b1;
                end
                if (src_busy) begin
                    wait_cnt++;
                    if (wait_cnt > 200) begin
                        chk("rnd_timeout", 32'(wait_cnt), 0);
                        break;
                    end
                end
                bus.m_tready = 1'($urandom_range(0, 1));
                pre_acc  = bus.m_tvalid & bus.m_tready;
                pre_hold = bus.m_tvalid & ~bus.m_tready;
                pre_data = bus.m_tdata;
                cyc();
                if (pre_acc) begin
                    if (q.size() == 0) begin
                        chk("rnd_spurious", 32'(pre_data), 32'hFFFF_FFFF);
                    end else begin
                        chk("rnd_data", 32'(pre_data), 32'(q.pop_front()));
                    end
                    exp_ack = ~exp_ack;
                    n_acc++;
                    chk("rnd_tv_drop", 32'(bus.m_tvalid), 0);
                end
                if (pre_hold) begin
                    chk("rnd_hold_v", 32'(bus.m_tvalid), 1);
                    chk("rnd_hold_d", 32'(bus.m_tdata), 32'(pre_data));
                end
                chk("rnd_ack", 32'(bus.dst_ack), 32'(exp_ack));
            end
            chk("rnd_drained", q.size(), 0);
            chk("rnd_some_beats", 32'(n_acc > 20), 1);
`ifdef ARCH_CDC_HS_COUNT_EN
            chk("cnt_value", 32'(xfer_count), 32'(16'(n_acc + 1)));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
